// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one external memory port between I-cache line refills
//             and D-cache line refills/write-backs, one burst per grant.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  localparam int LINE_BITS = 32 * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 ic_req,
  input  logic [ADDR_W-1:0]    ic_addr,
  output logic                 ic_ready,
  output logic [LINE_BITS-1:0] ic_line,

  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [LINE_BITS-1:0] dc_wline,
  output logic                 dc_ready,
  output logic [LINE_BITS-1:0] dc_line,

  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack,

  output logic                 busy,
  output logic                 grant_d
);

  localparam int                  c_beat_w    = $clog2(LINE_WORDS);
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(LINE_WORDS - 1);
  localparam logic [c_beat_w-1:0] c_beat_one  = c_beat_w'(1);
  localparam logic [ADDR_W-1:0]   c_off_mask  = ADDR_W'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [c_beat_w-1:0]           r_beat;
  logic                          r_last_d;
  logic                          r_grant_d;
  logic                          r_we;
  logic [ADDR_W-1:0]             r_base;
  logic [LINE_WORDS-1:0][31:0]   r_wline;
  logic [LINE_WORDS-1:0][31:0]   r_buf;
  logic [LINE_WORDS-1:0][31:0]   r_ic_line;
  logic [LINE_WORDS-1:0][31:0]   r_dc_line;
  logic [LINE_WORDS-1:0][31:0]   w_buf_nxt;

  logic                          w_grant;
  logic                          w_pick_d;
  logic                          w_beat_ack;
  logic                          w_last_beat;
  logic                          w_in_burst;
  logic                          w_in_done;

  // Round-robin: on contention the side that did not win last time goes first.
  assign w_pick_d    = dc_req & (~ic_req | ~r_last_d);
  assign w_last_beat = (r_beat == c_last_beat);
  assign w_in_burst  = (r_state == ST_BURST);
  assign w_in_done   = (r_state == ST_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_beat_ack  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ic_req | dc_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (mem_ack) begin
          w_beat_ack = 1'b1;
          if (w_last_beat) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_buf_nxt         = r_buf;
    w_buf_nxt[r_beat] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_last_d  <= 1'b1;
      r_grant_d <= 1'b0;
      r_we      <= 1'b0;
      r_base    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_beat    <= '0;
        r_grant_d <= w_pick_d;
        r_last_d  <= w_pick_d;
        r_we      <= w_pick_d & dc_we;
        r_base    <= (w_pick_d ? dc_addr : ic_addr) & ~c_off_mask;
      end else if (w_beat_ack) begin
        r_beat <= r_beat + c_beat_one;
      end
    end
  end

  // The visible line is loaded on the final read ack so it is already valid
  // during the ready pulse; write bursts never touch the line registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wline   <= '0;
      r_buf     <= '0;
      r_ic_line <= '0;
      r_dc_line <= '0;
    end else begin
      if (w_grant && w_pick_d) begin
        r_wline <= dc_wline;
      end
      if (w_beat_ack && !r_we) begin
        r_buf <= w_buf_nxt;
        if (w_last_beat) begin
          if (r_grant_d) begin
            r_dc_line <= w_buf_nxt;
          end else begin
            r_ic_line <= w_buf_nxt;
          end
        end
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign grant_d   = r_grant_d;
  assign mem_req   = w_in_burst;
  assign mem_we    = w_in_burst & r_we;
  assign mem_addr  = w_in_burst ? (r_base | ADDR_W'({r_beat, 2'b00})) : '0;
  assign mem_wdata = w_in_burst ? r_wline[r_beat] : 32'd0;
  assign ic_ready  = w_in_done & ~r_grant_d;
  assign dc_ready  = w_in_done &  r_grant_d;
  assign ic_line   = r_ic_line;
  assign dc_line   = r_dc_line;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed and randomized bench for mem_arbiter with a reference
//             memory model and line/arbitration expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LW     = 4;
  localparam int LB     = 32 * LW;
  localparam int AW     = 32;
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ic_req = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic          ic_ready;
  logic [LB-1:0] ic_line;
  logic          dc_req = 1'b0;
  logic          dc_we = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [LB-1:0] dc_wline = '0;
  logic          dc_ready;
  logic [LB-1:0] dc_line;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          busy;
  logic          grant_d;

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_line(ic_line),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wline(dc_wline),
    .dc_ready(dc_ready), .dc_line(dc_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  int            stall_n = 0;
  int            spurious = 0;
  logic [31:0]   mem_xor = '0;
  logic [31:0]   rec_addr[$];
  logic          rec_we[$];
  logic [31:0]   rec_wdata[$];

  // Reference state: expected visible lines and who won the last grant.
  logic [LB-1:0] exp_ic = '0;
  logic [LB-1:0] exp_dc = '0;
  bit            last_d = 1'b1;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  function automatic logic [LB-1:0] line_of(input logic [31:0] a);
    logic [LB-1:0] r;
    r = '0;
    for (int k = 0; k < LW; k++) r[k*32 +: 32] = (line_base(a) + 32'(4 * k)) ^ mem_xor;
    return r;
  endfunction

  // Memory responder: fixed stall per beat, checks held outputs while stalled.
  initial begin
    int          cnt;
    logic [31:0] ha, hw;
    logic        hwe;
    cnt = 0; ha = '0; hw = '0; hwe = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst && mem_req) begin
        if (cnt == 0) begin
          ha = mem_addr; hw = mem_wdata; hwe = mem_we;
        end else begin
          chk32("hold_addr", mem_addr, ha);
          chk32("hold_wdata", mem_wdata, hw);
          chk32("hold_we", {31'd0, mem_we}, {31'd0, hwe});
        end
        if (cnt >= stall_n) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ mem_xor;
          rec_addr.push_back(mem_addr);
          rec_we.push_back(mem_we);
          rec_wdata.push_back(mem_wdata);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_rec();
    rec_addr.delete(); rec_we.delete(); rec_wdata.delete();
  endtask

  task automatic wait_ready(input bit is_d, output int lat);
    lat = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk); #1;
      if (is_d ? dc_ready : ic_ready) begin
        lat = n;
        break;
      end
      if (is_d ? ic_ready : dc_ready) spurious++;
    end
    chk32("ready_seen", {31'd0, lat != 0}, 32'd1);
  endtask

  task automatic check_beats(input string tag, input logic [31:0] a, input bit we,
                             input logic [LB-1:0] wl);
    chk32({tag, "_nbeats"}, {31'd0, rec_addr.size() >= LW}, 32'd1);
    for (int k = 0; k < LW; k++) begin
      if (rec_addr.size() > 0) begin
        chk32({tag, "_addr"}, rec_addr.pop_front(), line_base(a) + 32'(4 * k));
        chk32({tag, "_we"}, {31'd0, rec_we.pop_front()}, {31'd0, we});
        if (we) chk32({tag, "_wdata"}, rec_wdata.pop_front(), wl[k*32 +: 32]);
        else    void'(rec_wdata.pop_front());
      end
    end
  endtask

  task automatic model_done(input bit is_d, input bit we, input logic [31:0] a);
    if (!we) begin
      if (is_d) exp_dc = line_of(a);
      else      exp_ic = line_of(a);
    end
    last_d = is_d;
  endtask

  task automatic check_idle_after(input string tag);
    @(posedge clk); #1;
    chk32({tag, "_rdy_low"}, {30'd0, ic_ready, dc_ready}, 32'd0);
    chk32({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk32({tag, "_spurious"}, 32'(spurious), 32'd0);
    chk32({tag, "_extra_beats"}, 32'(rec_addr.size()), 32'd0);
  endtask

  task automatic single(input string tag, input bit is_d, input bit we,
                        input logic [31:0] a, input logic [LB-1:0] wl, input int stall);
    int lat;
    stall_n = stall; spurious = 0; clear_rec();
    if (is_d) begin dc_req = 1'b1; dc_we = we; dc_addr = a; dc_wline = wl; end
    else begin ic_req = 1'b1; ic_addr = a; end
    wait_ready(is_d, lat);
    if (is_d) dc_req = 1'b0; else ic_req = 1'b0;
    chk32({tag, "_latency"}, 32'(lat), 32'(1 + LW * (stall + 1)));
    chk32({tag, "_grant_d"}, {31'd0, grant_d}, {31'd0, is_d});
    model_done(is_d, we, a);
    chk({tag, "_ic_line"}, ic_line, exp_ic);
    chk({tag, "_dc_line"}, dc_line, exp_dc);
    check_beats(tag, a, is_d & we, wl);
    check_idle_after(tag);
  endtask

  task automatic both(input string tag, input bit we_d, input logic [31:0] ai,
                      input logic [31:0] ad, input logic [LB-1:0] wl, input int stall);
    int  lat;
    bit  first_d;
    first_d = !last_d;
    stall_n = stall; spurious = 0; clear_rec();
    ic_req = 1'b1; ic_addr = ai;
    dc_req = 1'b1; dc_we = we_d; dc_addr = ad; dc_wline = wl;
    lat = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk); #1;
      if (ic_ready | dc_ready) begin lat = n; break; end
    end
    chk32({tag, "_first_latency"}, 32'(lat), 32'(1 + LW * (stall + 1)));
    chk32({tag, "_first_is_d"}, {30'd0, ic_ready, dc_ready}, first_d ? 32'd1 : 32'd2);
    chk32({tag, "_grant_d1"}, {31'd0, grant_d}, {31'd0, first_d});
    if (first_d) dc_req = 1'b0; else ic_req = 1'b0;
    model_done(first_d, first_d & we_d, first_d ? ad : ai);
    wait_ready(!first_d, lat);
    if (first_d) ic_req = 1'b0; else dc_req = 1'b0;
    chk32({tag, "_second_latency"}, 32'(lat), 32'(2 + LW * (stall + 1)));
    chk32({tag, "_grant_d2"}, {31'd0, grant_d}, {31'd0, !first_d});
    model_done(!first_d, !first_d & we_d, first_d ? ai : ad);
    chk({tag, "_ic_line"}, ic_line, exp_ic);
    chk({tag, "_dc_line"}, dc_line, exp_dc);
    if (first_d) begin
      check_beats({tag, "_d"}, ad, we_d, wl);
      check_beats({tag, "_i"}, ai, 1'b0, wl);
    end else begin
      check_beats({tag, "_i"}, ai, 1'b0, wl);
      check_beats({tag, "_d"}, ad, we_d, wl);
    end
    check_idle_after(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk32({tag, "_flags"}, {26'd0, ic_ready, dc_ready, mem_req, mem_we, busy, grant_d}, 32'd0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_ic_line"}, ic_line, '0);
    chk({tag, "_dc_line"}, dc_line, '0);
  endtask

  initial begin
    int          lat;
    logic [LB-1:0] wl;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_release");

    // Single I read; rdata equals the beat address
    mem_xor = 32'd0;
    single("i_read", 1'b0, 1'b0, 32'h0000_1238, '0, 0);
    chk("i_read_const", ic_line, 128'h0000123C_00001238_00001234_00001230);

    // D write-back with 3 stall cycles per beat
    wl = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    single("d_write", 1'b1, 1'b1, 32'h0000_0040, wl, 3);
    chk("d_write_dcline", dc_line, '0);

    // Contention: last grant was D, so I goes first; alternation continues
    mem_xor = 32'h5A5A_0000;
    both("cont1", 1'b0, 32'h0000_2004, 32'h0000_3010, '0, 0);
    both("cont2", 1'b0, 32'h0000_2100, 32'h0000_3300, '0, 1);

    // D read with request dropped and address changed during beat 1
    stall_n = 0; spurious = 0; clear_rec();
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0A0C;
    repeat (2) @(posedge clk);
    #1;
    chk32("drop_in_beat1", {31'd0, mem_req}, 32'd1);
    dc_req = 1'b0; dc_addr = 32'hFFFF_FFF0;
    wait_ready(1'b1, lat);
    chk32("drop_latency", 32'(lat), 32'(LW - 1));
    model_done(1'b1, 1'b0, 32'h0000_0A0C);
    chk("drop_dc_line", dc_line, exp_dc);
    check_beats("drop", 32'h0000_0A0C, 1'b0, '0);
    check_idle_after("drop");

    // Back-to-back: req held through ready, second line starts after a dead cycle
    spurious = 0; clear_rec();
    ic_req = 1'b1; ic_addr = 32'h0000_5000;
    wait_ready(1'b0, lat);
    chk32("b2b_lat1", 32'(lat), 32'(LW + 1));
    model_done(1'b0, 1'b0, 32'h0000_5000);
    chk("b2b_line1", ic_line, exp_ic);
    ic_addr = 32'h0000_6014;
    @(posedge clk); #1;
    chk32("b2b_dead", {30'd0, busy, ic_ready}, 32'd0);
    wait_ready(1'b0, lat);
    ic_req = 1'b0;
    chk32("b2b_lat2", 32'(lat), 32'(LW + 1));
    model_done(1'b0, 1'b0, 32'h0000_6014);
    chk("b2b_line2", ic_line, exp_ic);
    check_beats("b2b_a", 32'h0000_5000, 1'b0, '0);
    check_beats("b2b_b", 32'h0000_6014, 1'b0, '0);
    check_idle_after("b2b");

    // Reset during beat 2 aborts the burst without a ready pulse
    spurious = 0;
    ic_req = 1'b1; ic_addr = 32'h0000_7000;
    repeat (3) @(posedge clk);
    #1;
    chk32("mid_in_burst", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk32("mid_req_drop", {30'd0, mem_req, busy}, 32'd0);
    ic_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      chk32("mid_no_ready", {30'd0, ic_ready, dc_ready}, 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    exp_ic = '0; exp_dc = '0; last_d = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_after");
    clear_rec();

    // First contention after reset goes to I
    both("cont_rst", 1'b1, 32'h0000_8008, 32'h0000_9000,
         {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444}, 0);

    // Randomized traffic
    for (int it = 0; it < 16; it++) begin
      int          mode, st;
      logic [31:0] ai, ad;
      mode    = int'($urandom_range(0, 3));
      st      = int'($urandom_range(0, 2));
      mem_xor = $urandom;
      ai      = $urandom;
      ad      = $urandom;
      wl      = {$urandom, $urandom, $urandom, $urandom};
      case (mode)
        0:       single("rnd_i",  1'b0, 1'b0, ai, wl, st);
        1:       single("rnd_dr", 1'b1, 1'b0, ad, wl, st);
        2:       single("rnd_dw", 1'b1, 1'b1, ad, wl, st);
        default: both("rnd_both", 1'($urandom_range(0, 1)), ai, ad, wl, st);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single external memory port between I-cache refills (read-only) and D-cache refills/write-backs.
- Each granted request runs as a burst of LINE_WORDS 32-bit beats. Read beats are assembled into a line buffer; write lines are serialised out beat by beat.
- Completion is signalled to the granted cache with a one-cycle ready pulse.
- Sits between both cache controllers' mem_r/mem_ready handshake and the memory bus.

Parameters:
- LINE_WORDS, 4: words per cache line; power of 2, ≥2.
- ADDR_W, 32: byte address width.
- LINE_BITS (localparam) = 32*LINE_WORDS.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ic_req  in  1  I-cache line read request; level, held until ic_ready
- ic_addr  in  ADDR_W  I-cache miss address
- ic_ready  out  1  one-cycle pulse, ic_line valid
- ic_line  out  LINE_BITS  fetched line; word k at bits [32k+31:32k]
- dc_req  in  1  D-cache request; level, held until dc_ready
- dc_we  in  1  1 = write line to memory, 0 = read line
- dc_addr  in  ADDR_W  D-cache line address
- dc_wline  in  LINE_BITS  line to write; sampled at grant
- dc_ready  out  1  one-cycle pulse, transaction complete
- dc_line  out  LINE_BITS  fetched line for D reads
- mem_req  out  1  beat request to memory
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  32  beat write data
- mem_rdata  in  32  beat read data, valid with mem_ack
- mem_ack  in  1  beat accepted/completed this cycle
- busy  out  1  arbiter not in IDLE
- grant_d  out  1  current/last grant is D-cache

Behaviour:
- Reset (rst=0, immediate):
  - state=IDLE, beat=0, last_grant=D, all buffers 0.
  - Outputs: ic_ready, dc_ready, mem_req, mem_we, busy, grant_d = 0; mem_addr, mem_wdata, ic_line, dc_line = 0.
  - Reset mid-burst aborts the burst: mem_req drops asynchronously and no ready pulse is issued.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - No requests: stay in IDLE.
  - One request: grant it.
  - Both requests: round-robin; grant the requester opposite last_grant. The first contention after reset goes to I.
  - At grant, latch:
    - base = addr with low log2(LINE_WORDS)+2 bits cleared.
    - we: dc_we for D, 0 for I.
    - wline: dc_wline for D.
    - grant_d.
  - Then go to BURST with beat=0 and update last_grant.
- BURST:
  - mem_req=1, mem_we=latched we, mem_addr = base + 4*beat, mem_wdata = wline word[beat].
  - Outputs are registered-stable while waiting for mem_ack; arbitrary ack latency is allowed.
  - On mem_ack:
    - If read, write mem_rdata into buffer word[beat].
    - beat += 1. Addresses never cross the line, so there is no wrap.
    - On the ack of beat LINE_WORDS-1, go to DONE.
    - mem_req is deasserted in the cycle after the final ack.
- DONE:
  - Pulse ic_ready or dc_ready for exactly one cycle, per grant_d.
  - Update ic_line/dc_line from the buffer; the line holds stable until the next completed read to that port.
  - Next cycle: IDLE.
  - Requests are not sampled in DONE or BURST.
- Requester contract: req drops by the cycle after its ready. A req still high in IDLE is treated as a new request.
- Mid-burst changes: a req dropping or an address changing mid-burst is ignored; the burst completes and ready still pulses.
- Writes leave the dc_line/ic_line buffers unchanged.
- busy=1 in BURST and DONE.
- Latency with mem_ack tied high: grant cycle + LINE_WORDS beats + DONE. Ready is asserted LINE_WORDS+1 cycles after the first IDLE cycle with a request.

Test Plan:
- Reset: rst=0 during BURST beat 2 → mem_req=0 in the same cycle, no ready pulse. After release, IDLE with busy=0 and all outputs 0.
- Single I read: ic_req=1, ic_addr=0x0000_1238, LINE_WORDS=4, mem_ack=1 always, rdata=beat address.
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - ic_ready pulses at cycle 5.
  - ic_line = {0x123C, 0x1238, 0x1234, 0x1230}.
- D write-back: dc_req=1, dc_we=1, dc_addr=0x40, dc_wline={D,C,B,A}; mem_ack stalled 3 cycles per beat.
  - mem_we=1 throughout.
  - mem_wdata A, B, C, D, each held until its ack.
  - dc_ready one pulse; dc_line unchanged.
- Contention: ic_req and dc_req both high after reset → I served first, then D.
  - Repeat the simultaneous requests → grants alternate I, D, I, D.
  - grant_d tracks each grant.
- Request drop: dc_req deasserted in beat 1 → burst finishes all 4 beats and dc_ready still pulses once.
- Back-to-back: ic_req held high through ic_ready → a second burst starts from IDLE. Proves the DONE→IDLE dead cycle and re-arbitration.
